// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
//   state_e : sequencer FSM states
//   tag_t   : per-issue tag carried alongside the slice pipeline
//   OPM_*   : OPMODE words presented to the slice
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // OPMODE[3:2] selects Z, OPMODE[1:0] selects X. Upper bits stay zero:
  // add, no pre-adder, carry-in 0.
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P

  function automatic logic [7:0] tag_opmode(input logic valid, input logic first);
    if (!valid) begin
      return OPM_HOLD;
    end
    return first ? OPM_FIRST : OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Shift register of issue tags that tracks operand pairs through the slice.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tag_i          : tag of the pair issued this cycle (valid=0 for bubbles)
//   stage1_valid_o : stage 1 holds a pair (one cycle after issue)
//   stage1_first_o : that pair is the first of its job
//   capture_o      : stage Depth holds the last pair of the job
module dsp_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output logic stage1_valid_o,
  output logic stage1_first_o,
  output logic capture_o
);

  tag_t pipe_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(Depth); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign stage1_valid_o = pipe_q[0].valid;
  assign stage1_first_o = pipe_q[0].first;
  assign capture_o      = pipe_q[Depth-1].valid & pipe_q[Depth-1].last;

endmodule

// File: rtl/dsp_mac_seq.sv
// Streaming multiply-accumulate sequencer for one DSP48A1 slice.
// Accepts a job length, streams that many (a, b) pairs into the slice and
// returns the 48-bit dot product with a one-cycle result_valid pulse.
//   CLK, RST                 : clock, asynchronous active-high reset
//   start, len               : job request and length (sampled in idle)
//   in_valid, in_ready       : operand stream handshake
//   a_in, b_in               : operands
//   dsp_A/B, dsp_CEA/CEB     : slice operand inputs and clock enables
//   dsp_OPMODE, dsp_P        : slice opmode (registered in slice) and P output
//   busy, result, result_valid : status and final accumulation
module dsp_mac_seq
  import dsp_seq_pkg::*;
#(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic             dsp_CEA,
  output logic             dsp_CEB,
  output logic [7:0]       dsp_OPMODE,
  input  logic [47:0]      dsp_P,
  output logic             busy,
  output logic [47:0]      result,
  output logic             result_valid
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [47:0]      result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             zero_q, zero_d;  // marks the done cycle of a zero-length job

  logic issue;
  logic capture;
  logic stage1_valid;
  logic stage1_first;
  tag_t tag_in;

  assign in_ready = (state_q == StRun);
  assign issue    = in_valid & in_ready;

  assign dsp_CEA = issue;
  assign dsp_CEB = issue;
  assign dsp_A   = issue ? a_in : '0;
  assign dsp_B   = issue ? b_in : '0;

  assign tag_in.valid = issue;
  assign tag_in.first = issue & (cnt_q == '0);
  assign tag_in.last  = issue & (cnt_q == len_q - LEN_W'(1));

  dsp_tag_pipe #(
    .Depth(PIPE_LAT)
  ) u_tag_pipe (
    .clk_i         (CLK),
    .rst_i         (RST),
    .tag_i         (tag_in),
    .stage1_valid_o(stage1_valid),
    .stage1_first_o(stage1_first),
    .capture_o     (capture)
  );

  // Driven from stage 1 because the slice registers OPMODE alongside M.
  assign dsp_OPMODE = tag_opmode(stage1_valid, stage1_first);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    zero_d         = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (len != '0) begin
            len_d   = len;
            state_d = StRun;
          end else begin
            zero_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (issue) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (tag_in.last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (capture) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (zero_q) begin
          result_d       = '0;
          result_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      result_d       = dsp_P;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= StIdle;
      len_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      zero_q         <= zero_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: doc/dsp_mac_seq.md
# dsp_mac_seq

Sequencer that drives one DSP48A1 slice as a streaming multiply-accumulate engine. It accepts a job length, then takes that many (a, b) operand pairs over a valid/ready stream. For each pair it drives the slice's A/B inputs, clock enables and OPMODE, and returns the 48-bit dot product with a one-cycle valid pulse. It sits between a sample/coefficient source and the slice, which is built with A0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, CEOPMODE tied high, B_INPUT="DIRECT" and CARRYINSEL="OPMODE5".

## Interface
- LEN_W, 8, width of job length; maximum job length is 2^LEN_W-1
- PIPE_LAT, 3, slice latency from A/B issue to P update (A1/B1 reg, M reg, P reg)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_W  number of operand pairs; sampled with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- a_in, b_in  in  18 each  operands
- dsp_A, dsp_B  out  18 each  to slice A/B
- dsp_CEA, dsp_CEB  out  1 each  to slice CEA/CEB
- dsp_OPMODE  out  8  to slice OPMODE
- dsp_P  in  48  from slice P
- busy  out  1  high outside IDLE
- result  out  48  final accumulation, held until next job completes
- result_valid  out  1  one-cycle pulse when result updates

## Operation
- Definition: an issue is a cycle with in_valid & in_ready.
- FSM states and transitions:
  - IDLE -> RUN on start with len>0; the length is latched.
  - IDLE -> DONE on start with len==0.
  - RUN -> DRAIN on the issue of pair len-1.
  - DRAIN -> DONE when the result capture fires.
  - DONE -> IDLE unconditionally.
- in_ready = (state==RUN). start is ignored outside IDLE.
- On an issue, dsp_A/dsp_B carry a_in/b_in combinationally and dsp_CEA = dsp_CEB = 1. Otherwise both CEs are 0.
- A tag pipeline (valid, first) shifts every cycle. dsp_OPMODE is driven from tag stage 1 (one cycle after issue), because the slice registers OPMODE:
  - 8'h01 for the first pair of a job (X=M, Z=0; clears the accumulator).
  - 8'h09 for later pairs (X=M, Z=P).
  - 8'h08 for bubbles and when idle (X=0, Z=P; holds P).
  - Bits 7/6/5/4 are always 0: add, no pre-adder, carry-in 0.
- Arithmetic: the accumulator is 48-bit and wraps modulo 2^48, with no saturation. Operand range is the bench's responsibility.
- Capture: in the cycle that tag stage PIPE_LAT holds the last pair, result <= dsp_P and result_valid pulses the next cycle (in DONE).
- A len==0 job gives result=0 and result_valid 2 cycles after start. The slice is not touched.

## Timing
- Reset values:
  - state = IDLE, in_ready = 0, busy = 0
  - dsp_CEA = dsp_CEB = 0, dsp_OPMODE = 8'h08
  - dsp_A = dsp_B = 0, result = 0, result_valid = 0
  - tag pipeline cleared
- Latency: last issue at cycle t -> dsp_P final value in t+3 -> result_valid high in t+4.
- Bubbles (in_valid low during RUN) add no error. They only shift the completion time.
- Back-to-back jobs: start is accepted in the cycle after result_valid (IDLE).
- Reset mid-job: everything returns to its reset value asynchronously. Partial sums are discarded and no result_valid is produced. The slice's RST* pins are driven from RST by the top level.
- An in_valid pulse without in_ready has no effect. The source must hold its data.

## Structure
- Package dsp_seq_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the OPMODE constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_HOLD=8'h08
- One sub-module, dsp_tag_pipe: a PIPE_LAT-deep shift register of {valid, first, last}, cleared by RST.
- The bench instantiates dsp_mac_seq together with the real DSP48A1.

## Test plan
- len=4, a={1,2,3,4}, b={5,6,7,8}, in_valid held high:
  - result=70, result_valid 4 cycles after the last issue.
  - OPMODE sequence 01,09,09,09 then 08.
- Same vectors with in_valid low for 2 cycles between pairs 2 and 3:
  - result=70; OPMODE=08 during the bubbles.
- len=1, a=3, b=4 -> result=12; len=0 -> result=0, result_valid 2 cycles after start, CEA never high.
- Two back-to-back jobs:
  - {2,2}·{3,3}=12, then {1}·{9}=9.
  - The second job's first pair uses OPMODE 01, so there is no carry-over of the 12.
- start pulsed during RUN is ignored; RST asserted mid-RUN -> all outputs at reset values immediately, no result_valid, next job correct.
